// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: bundles every non-clock/reset signal of the pipelined
// register file so the controller and the file share one typed connection.
//   master modport : the pipeline controller (drives addresses, strobes)
//   slave modport  : the register file (drives read data, hazards, flags)
// Signal groups:
//   read ports  rd_en1/2, rd_addr1/2 -> rd_data1/2, hazard1/2, stall
//   write port  wr_en, wr_addr, wr_data
//   scoreboard  issue_en, issue_addr, flush -> err_overflow, err_underflow
//   debug       dbg_sel -> dbg_data
interface pipe_regfile_if #(
  parameter int DATA_W   = 8,
  parameter int NREG     = 4,
  parameter int ADDR_W   = $clog2(NREG),
  parameter int PEND_MAX = 3
);
  logic              rd_en1;
  logic              rd_en2;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              flush;
  logic              stall;
  logic              hazard1;
  logic              hazard2;
  logic              err_overflow;
  logic              err_underflow;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_en1, rd_en2, rd_addr1, rd_addr2,
    output wr_en, wr_addr, wr_data,
    output issue_en, issue_addr, flush, dbg_sel,
    input  rd_data1, rd_data2, stall, hazard1, hazard2,
    input  err_overflow, err_underflow, dbg_data
  );

  modport slave (
    input  rd_en1, rd_en2, rd_addr1, rd_addr2,
    input  wr_en, wr_addr, wr_data,
    input  issue_en, issue_addr, flush, dbg_sel,
    output rd_data1, rd_data2, stall, hazard1, hazard2,
    output err_overflow, err_underflow, dbg_data
  );
endinterface

// File: rtl/pipe_regfile.sv
// pipe_regfile: NREG x DATA_W register file with two combinational read
// ports (write-through bypass), one write port, a per-register counter of
// outstanding writes, and a debug read port without bypass.
// Ports:
//   clock  rising-edge clock for all state
//   reset  synchronous active-high, clears registers, counters and flags
//   bus    pipe_regfile_if.slave (read/write/scoreboard/debug signals)
// Hazards and stall are combinational from the current counters; the
// overflow/underflow flags are sticky until reset.
module pipe_regfile #(
  parameter int DATA_W   = 8,
  parameter int NREG     = 4,
  parameter int ADDR_W   = $clog2(NREG),
  parameter int PEND_MAX = 3
) (
  input logic          clock,
  input logic          reset,
  pipe_regfile_if.slave bus
);
  localparam int CW = $clog2(PEND_MAX + 1);
  localparam logic [CW-1:0] PEND_ZERO = '0;
  localparam logic [CW-1:0] PEND_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] PEND_FULL = CW'(PEND_MAX);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [CW-1:0]     pend_r [NREG];
  logic [CW-1:0]     pend_nxt_s [NREG];
  logic              err_ovf_r;
  logic              err_unf_r;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              hit1_s;
  logic              hit2_s;
  logic              hazard1_s;
  logic              hazard2_s;

  // Read ports with same-cycle write-through bypass; rd_en does not gate data.
  always_comb begin
    hit1_s = bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    hit2_s = bus.wr_en && (bus.wr_addr == bus.rd_addr2);
    if (hit1_s) begin
      bus.rd_data1 = bus.wr_data;
    end else begin
      bus.rd_data1 = regs_r[bus.rd_addr1];
    end
    if (hit2_s) begin
      bus.rd_data2 = bus.wr_data;
    end else begin
      bus.rd_data2 = regs_r[bus.rd_addr2];
    end
    bus.dbg_data = regs_r[bus.dbg_sel];
  end

  // Hazard detection: a read of a register with outstanding writes stalls,
  // unless the only outstanding write is retiring now and is bypassed.
  always_comb begin
    hazard1_s = bus.rd_en1 && (pend_r[bus.rd_addr1] != PEND_ZERO)
                && !(hit1_s && (pend_r[bus.rd_addr1] == PEND_ONE));
    hazard2_s = bus.rd_en2 && (pend_r[bus.rd_addr2] != PEND_ZERO)
                && !(hit2_s && (pend_r[bus.rd_addr2] == PEND_ONE));
    bus.hazard1       = hazard1_s;
    bus.hazard2       = hazard2_s;
    bus.stall         = hazard1_s | hazard2_s;
    bus.err_overflow  = err_ovf_r;
    bus.err_underflow = err_unf_r;
  end

  // Scoreboard next state: issue increments, retire decrements, both cancel.
  // Flush wins over everything and leaves the sticky flags alone.
  always_comb begin
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt_s[i] = pend_r[i];
      if (bus.flush) begin
        pend_nxt_s[i] = PEND_ZERO;
      end else begin
        case ({bus.issue_en && (bus.issue_addr == ADDR_W'(i)),
               bus.wr_en && (bus.wr_addr == ADDR_W'(i))})
          2'b10: begin
            if (pend_r[i] == PEND_FULL) begin
              ovf_set_s = 1'b1;
            end else begin
              pend_nxt_s[i] = pend_r[i] + PEND_ONE;
            end
          end
          2'b01: begin
            if (pend_r[i] == PEND_ZERO) begin
              unf_set_s = 1'b1;
            end else begin
              pend_nxt_s[i] = pend_r[i] - PEND_ONE;
            end
          end
          default: pend_nxt_s[i] = pend_r[i];
        endcase
      end
    end
  end

  // Register storage; reset blocks any write issued in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (bus.wr_en) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Pending counters and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= PEND_ZERO;
      end
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= pend_nxt_s[i];
      end
      err_ovf_r <= err_ovf_r | ovf_set_s;
      err_unf_r <= err_unf_r | unf_set_s;
    end
  end
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed table of per-cycle vectors with hand-computed
// expected outputs for pipe_regfile (DATA_W=8, NREG=4, PEND_MAX=3), plus a
// hand-written reset sequence with a write held high during reset.
module tb_pipe_regfile;
  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_regfile_if #(.DATA_W(8), .NREG(4), .PEND_MAX(3)) bus ();

  pipe_regfile #(.DATA_W(8), .NREG(4), .PEND_MAX(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       re1; logic [1:0] a1;
    logic       re2; logic [1:0] a2;
    logic       we;  logic [1:0] wa; logic [7:0] wd;
    logic       ie;  logic [1:0] ia;
    logic       fl;  logic [1:0] ds;
    logic [7:0] e1;  logic [7:0] e2;
    logic       h1;  logic       h2;
    logic [7:0] ed;
    logic       eo;  logic       eu;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(int re1, int a1, int re2, int a2,
                             int we, int wa, int wd, int ie, int ia,
                             int fl, int ds, int e1, int e2, int h1, int h2,
                             int ed, int eo, int eu);
    vec_t s;
    s.re1 = re1[0]; s.a1 = a1[1:0]; s.re2 = re2[0]; s.a2 = a2[1:0];
    s.we = we[0]; s.wa = wa[1:0]; s.wd = wd[7:0];
    s.ie = ie[0]; s.ia = ia[1:0]; s.fl = fl[0]; s.ds = ds[1:0];
    s.e1 = e1[7:0]; s.e2 = e2[7:0]; s.h1 = h1[0]; s.h2 = h2[0];
    s.ed = ed[7:0]; s.eo = eo[0]; s.eu = eu[0];
    return s;
  endfunction

  task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_en1 = 1'b0; bus.rd_addr1 = 2'd0;
    bus.rd_en2 = 1'b0; bus.rd_addr2 = 2'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00;
    bus.issue_en = 1'b0; bus.issue_addr = 2'd0;
    bus.flush = 1'b0; bus.dbg_sel = 2'd0;
  endtask

  task automatic check_outputs(int idx, logic [7:0] e1, logic [7:0] e2,
                               logic h1, logic h2, logic [7:0] ed,
                               logic eo, logic eu);
    chk("rd_data1", idx, bus.rd_data1, e1);
    chk("rd_data2", idx, bus.rd_data2, e2);
    chk("hazard1", idx, {7'd0, bus.hazard1}, {7'd0, h1});
    chk("hazard2", idx, {7'd0, bus.hazard2}, {7'd0, h2});
    chk("stall", idx, {7'd0, bus.stall}, {7'd0, h1 | h2});
    chk("dbg_data", idx, bus.dbg_data, ed);
    chk("err_overflow", idx, {7'd0, bus.err_overflow}, {7'd0, eo});
    chk("err_underflow", idx, {7'd0, bus.err_underflow}, {7'd0, eu});
  endtask

  initial begin
    // Fill regs (issue+retire same reg, so no underflow)
    vq.push_back(v(0,0,0,1, 1,0,8'h11, 1,0, 0,0, 8'h11,8'h00,0,0,8'h00,0,0));
    vq.push_back(v(0,0,0,1, 1,1,8'h22, 1,1, 0,0, 8'h11,8'h22,0,0,8'h11,0,0));
    vq.push_back(v(0,2,0,3, 1,2,8'h33, 1,2, 0,1, 8'h33,8'h00,0,0,8'h22,0,0));
    vq.push_back(v(0,3,0,2, 1,3,8'h44, 1,3, 0,2, 8'h44,8'h33,0,0,8'h33,0,0));
    vq.push_back(v(1,0,1,3, 0,0,8'h00, 0,0, 0,3, 8'h11,8'h44,0,0,8'h44,0,0));
    vq.push_back(v(1,1,1,2, 0,0,8'h00, 0,0, 0,0, 8'h22,8'h33,0,0,8'h11,0,0));
    // Bypass vs debug port
    vq.push_back(v(0,2,0,0, 1,2,8'h05, 1,2, 0,2, 8'h05,8'h11,0,0,8'h33,0,0));
    vq.push_back(v(1,2,0,0, 1,2,8'hA7, 1,2, 0,2, 8'hA7,8'h11,0,0,8'h05,0,0));
    vq.push_back(v(1,2,0,0, 0,0,8'h00, 0,0, 0,2, 8'hA7,8'h11,0,0,8'hA7,0,0));
    // Hazard on r1: issue t, read t+1, t+2, retire t+3
    vq.push_back(v(1,1,0,0, 0,0,8'h00, 1,1, 0,1, 8'h22,8'h11,0,0,8'h22,0,0));
    vq.push_back(v(1,1,1,0, 0,0,8'h00, 0,0, 0,1, 8'h22,8'h11,1,0,8'h22,0,0));
    vq.push_back(v(1,1,1,1, 0,0,8'h00, 0,0, 0,1, 8'h22,8'h22,1,1,8'h22,0,0));
    vq.push_back(v(1,1,1,1, 1,1,8'h5A, 0,0, 0,1, 8'h5A,8'h5A,0,0,8'h22,0,0));
    vq.push_back(v(1,1,0,0, 0,0,8'h00, 0,0, 0,1, 8'h5A,8'h11,0,0,8'h5A,0,0));
    // Multi-pending r3
    vq.push_back(v(1,3,0,0, 0,0,8'h00, 1,3, 0,3, 8'h44,8'h11,0,0,8'h44,0,0));
    vq.push_back(v(1,3,0,3, 0,0,8'h00, 1,3, 0,3, 8'h44,8'h44,1,0,8'h44,0,0));
    vq.push_back(v(1,3,0,0, 1,3,8'h61, 0,0, 0,3, 8'h61,8'h11,1,0,8'h44,0,0));
    vq.push_back(v(1,3,0,0, 0,0,8'h00, 0,0, 0,3, 8'h61,8'h11,1,0,8'h61,0,0));
    vq.push_back(v(1,3,0,0, 1,3,8'h62, 1,3, 0,3, 8'h62,8'h11,0,0,8'h61,0,0));
    vq.push_back(v(1,3,0,0, 0,0,8'h00, 0,0, 0,3, 8'h62,8'h11,1,0,8'h62,0,0));
    vq.push_back(v(1,3,0,0, 1,3,8'h63, 0,0, 0,3, 8'h63,8'h11,0,0,8'h62,0,0));
    vq.push_back(v(1,3,0,0, 0,0,8'h00, 0,0, 0,3, 8'h63,8'h11,0,0,8'h63,0,0));
    // Overflow on r0: four issues, then three retires
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 1,0, 0,0, 8'h11,8'h11,0,0,8'h11,0,0));
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 1,0, 0,0, 8'h11,8'h11,1,0,8'h11,0,0));
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 1,0, 0,0, 8'h11,8'h11,1,0,8'h11,0,0));
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 1,0, 0,0, 8'h11,8'h11,1,0,8'h11,0,0));
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 0,0, 0,0, 8'h11,8'h11,1,0,8'h11,1,0));
    vq.push_back(v(1,0,0,0, 1,0,8'hA0, 0,0, 0,0, 8'hA0,8'hA0,1,0,8'h11,1,0));
    vq.push_back(v(1,0,0,0, 1,0,8'hA1, 0,0, 0,0, 8'hA1,8'hA1,1,0,8'hA0,1,0));
    vq.push_back(v(1,0,0,0, 1,0,8'hA2, 0,0, 0,0, 8'hA2,8'hA2,0,0,8'hA1,1,0));
    vq.push_back(v(1,0,0,0, 0,0,8'h00, 0,0, 0,0, 8'hA2,8'hA2,0,0,8'hA2,1,0));
    // Underflow: retire r2 with nothing pending, write still lands
    vq.push_back(v(1,2,0,0, 1,2,8'hB2, 0,0, 0,2, 8'hB2,8'hA2,0,0,8'hA7,1,0));
    vq.push_back(v(1,2,0,0, 0,0,8'h00, 0,0, 0,2, 8'hB2,8'hA2,0,0,8'hB2,1,1));
    // Flush: r0 pend 2, r1 pend 1, flush with issue r1 same cycle
    vq.push_back(v(0,0,0,1, 0,0,8'h00, 1,0, 0,0, 8'hA2,8'h5A,0,0,8'hA2,1,1));
    vq.push_back(v(1,0,0,1, 0,0,8'h00, 1,0, 0,0, 8'hA2,8'h5A,1,0,8'hA2,1,1));
    vq.push_back(v(1,0,1,1, 0,0,8'h00, 1,1, 0,0, 8'hA2,8'h5A,1,0,8'hA2,1,1));
    vq.push_back(v(1,0,1,1, 0,0,8'h00, 1,1, 1,0, 8'hA2,8'h5A,1,1,8'hA2,1,1));
    vq.push_back(v(1,0,1,1, 0,0,8'h00, 0,0, 0,0, 8'hA2,8'h5A,0,0,8'hA2,1,1));

    // Reset for two cycles
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    bus.rd_en1 = 1'b1; bus.rd_addr1 = 2'd1;
    bus.rd_en2 = 1'b1; bus.rd_addr2 = 2'd2;
    @(negedge clock);
    check_outputs(-1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clock); #1;

    // Table-driven vectors, one per cycle
    for (int i = 0; i < vq.size(); i++) begin
      bus.rd_en1 = vq[i].re1; bus.rd_addr1 = vq[i].a1;
      bus.rd_en2 = vq[i].re2; bus.rd_addr2 = vq[i].a2;
      bus.wr_en = vq[i].we; bus.wr_addr = vq[i].wa; bus.wr_data = vq[i].wd;
      bus.issue_en = vq[i].ie; bus.issue_addr = vq[i].ia;
      bus.flush = vq[i].fl; bus.dbg_sel = vq[i].ds;
      @(negedge clock);
      check_outputs(i, vq[i].e1, vq[i].e2, vq[i].h1, vq[i].h2, vq[i].ed,
                    vq[i].eo, vq[i].eu);
      @(posedge clock); #1;
    end

    // Reset with write, issue and flush active: nothing may commit
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'hFF;
    bus.issue_en = 1'b1; bus.issue_addr = 2'd1; bus.flush = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    idle_inputs();
    bus.rd_en1 = 1'b1; bus.rd_addr1 = 2'd1;
    bus.rd_en2 = 1'b1; bus.rd_addr2 = 2'd0;
    bus.dbg_sel = 2'd1;
    @(negedge clock);
    check_outputs(100, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      bus.dbg_sel = r[1:0];
      #1;
      chk("dbg_after_reset", 200 + r, bus.dbg_data, 8'h00);
    end
    @(posedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
